// File: rtl/matrix_stream_driver_pkg.sv
// rtl/matrix_stream_driver_pkg.sv - shared widths, FSM encoding and result-word helper
package matrix_stream_driver_pkg;

  localparam int ELEM_W = 8;
  localparam int RES_W  = 16;
  localparam int N_ELEM = 9;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  // Pull result element idx out of a packed C vector.
  function automatic logic [RES_W-1:0] res_word(
    input logic [N_ELEM*RES_W-1:0] vec,
    input logic [3:0]              idx
  );
    return vec[idx*RES_W +: RES_W];
  endfunction

endpackage

// File: rtl/matrix_stream_driver.sv
// rtl/matrix_stream_driver.sv - loads A/B byte stream, runs a 3x3 multiply, streams C words
module matrix_stream_driver
  import matrix_stream_driver_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_valid,
  input  logic [ELEM_W-1:0]        s_data,
  output logic                     s_ready,
  output logic                     mm_start,
  output logic [N_ELEM*ELEM_W-1:0] mm_A,
  output logic [N_ELEM*ELEM_W-1:0] mm_B,
  input  logic [N_ELEM*RES_W-1:0]  mm_C,
  input  logic                     mm_done,
  output logic                     m_valid,
  output logic [RES_W-1:0]         m_data,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     err
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam logic [4:0]       LAST_BYTE  = 5'(2 * N_ELEM - 1);
  localparam logic [4:0]       B_BASE     = 5'(N_ELEM);
  localparam logic [3:0]       LAST_WORD  = 4'(N_ELEM - 1);

  state_t                   state;
  logic [4:0]               n;
  logic [3:0]               k;
  logic [CNT_W-1:0]         wait_cnt;
  logic [N_ELEM*RES_W-1:0]  c_reg;

  logic [4:0] n_minus_b;
  logic [3:0] elem_idx;
  logic [3:0] k_nxt;
  logic       load_is_a;

  always_comb begin
    n_minus_b = n - B_BASE;
    load_is_a = (n < B_BASE);
    elem_idx  = load_is_a ? n[3:0] : n_minus_b[3:0];
    k_nxt     = k + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_LOAD;
      n        <= '0;
      k        <= '0;
      wait_cnt <= '0;
      mm_A     <= '0;
      mm_B     <= '0;
      c_reg    <= '0;
      mm_start <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      err      <= 1'b0;
      s_ready  <= 1'b1;
    end else begin
      mm_start <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (s_valid && s_ready) begin
            if (load_is_a) begin
              mm_A[elem_idx*ELEM_W +: ELEM_W] <= s_data;
            end else begin
              mm_B[elem_idx*ELEM_W +: ELEM_W] <= s_data;
            end
            if (n == LAST_BYTE) begin
              n        <= '0;
              s_ready  <= 1'b0;
              mm_start <= 1'b1;
              state    <= ST_START;
            end else begin
              n <= n + 5'd1;
            end
          end
        end

        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        // mm_done wins over the timeout when both land on the same cycle.
        ST_WAIT: begin
          if (mm_done) begin
            c_reg   <= mm_C;
            m_valid <= 1'b1;
            m_data  <= res_word(mm_C, 4'd0);
            m_last  <= 1'b0;
            k       <= '0;
            state   <= ST_STREAM;
          end else if (wait_cnt == WAIT_LIMIT) begin
            err      <= 1'b1;
            n        <= '0;
            wait_cnt <= '0;
            s_ready  <= 1'b1;
            state    <= ST_LOAD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_STREAM: begin
          if (m_ready) begin
            if (k == LAST_WORD) begin
              k       <= '0;
              m_valid <= 1'b0;
              m_data  <= '0;
              m_last  <= 1'b0;
              s_ready <= 1'b1;
              state   <= ST_LOAD;
            end else begin
              k      <= k_nxt;
              m_data <= res_word(c_reg, k_nxt);
              m_last <= (k_nxt == LAST_WORD);
            end
          end
        end

        default: begin
          s_ready <= 1'b1;
          state   <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_driver.sv
// tb/tb_matrix_stream_driver.sv - scoreboard bench with a behavioural 3x3 multiplier alongside the driver
module tb_matrix_stream_driver;
  import matrix_stream_driver_pkg::*;

  localparam int TO = 255;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_valid = 1'b0;
  logic [7:0]   s_data = 8'd0;
  logic         s_ready;
  logic         mm_start;
  logic [71:0]  mm_A, mm_B;
  logic [143:0] mm_C;
  logic         mm_done;
  logic         m_valid;
  logic [15:0]  m_data;
  logic         m_last;
  logic         m_ready = 1'b1;
  logic         err;

  matrix_stream_driver #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mm_start(mm_start), .mm_A(mm_A), .mm_B(mm_B), .mm_C(mm_C), .mm_done(mm_done),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] data; logic last; } word_t;
  word_t exp_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, starts = 0, errs = 0, start_cyc = -1, err_cyc = -1, hs_count = 0;
  bit valid_seen = 0;
  int ready_mode = 0;
  int a_m[9], b_m[9];
  bit done_en = 1;
  int mult_lat = 3;
  int lat_cnt = 0;
  bit busy = 0;
  bit stall = 0;
  logic [15:0] held_data;
  logic held_last;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Behavioural multiplier: result and done level appear mult_lat cycles after start.
  function automatic logic [143:0] mult(input logic [71:0] a, input logic [71:0] b);
    logic [143:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int s;
        s = 0;
        for (int q = 0; q < 3; q++) s += int'(a[8*(3*i+q) +: 8]) * int'(b[8*(3*q+j) +: 8]);
        r[16*(3*i+j) +: 16] = 16'(s);
      end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mm_C <= '0; mm_done <= 1'b0; busy <= 0; lat_cnt <= 0;
    end else if (mm_start) begin
      mm_C <= mult(mm_A, mm_B); mm_done <= 1'b0; busy <= 1; lat_cnt <= mult_lat;
    end else if (busy) begin
      if (lat_cnt <= 1) begin busy <= 0; mm_done <= done_en; end
      else lat_cnt <= lat_cnt - 1;
    end
  end

  // Reference: C = A x B over integers, reduced mod 2^16, streamed row-major.
  task automatic push_expected();
    for (int e = 0; e < 9; e++) begin
      int i, j, c;
      word_t w;
      i = e / 3; j = e % 3; c = 0;
      for (int q = 0; q < 3; q++) c += a_m[3*i+q] * b_m[3*q+j];
      w.data = 16'(c % 65536);
      w.last = (e == 8);
      exp_q.push_back(w);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = ((cyc % 3) == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        stall = 0;
      end else begin
        if (mm_start) begin starts++; start_cyc = cyc; end
        if (err) begin errs++; err_cyc = cyc; end
        if (m_valid) valid_seen = 1;
        if (stall && m_valid) begin
          check("stall_data", 144'(m_data), 144'(held_data));
          check("stall_last", 144'(m_last), 144'(held_last));
        end
        if (m_valid && m_ready) begin
          hs_count++;
          stall = 0;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_word: got %0h expected no word", m_data);
          end else begin
            word_t w;
            w = exp_q.pop_front();
            check("m_data", 144'(m_data), 144'(w.data));
            check("m_last", 144'(m_last), 144'(w.last));
          end
        end else if (m_valid) begin
          stall = 1; held_data = m_data; held_last = m_last;
        end else begin
          stall = 0;
        end
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bytes(input int gap);
    for (int i = 0; i < 18; i++) begin
      int t;
      t = 0;
      s_valid = 1'b1;
      s_data = 8'(i < 9 ? a_m[i] : b_m[i-9]);
      @(negedge clk);
      while (!s_ready && t < 500) begin t++; @(negedge clk); end
      if (t >= 500) bound_fail("load_s_ready");
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_data = 8'($urandom);
      for (int g = 0; g < gap; g++) align();
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk); #1;
    while ((exp_q.size() != 0 || m_valid) && t < 3000) begin t++; @(negedge clk); #1; end
    if (t >= 3000) bound_fail("drain");
    check("queue_empty", 144'(exp_q.size()), 144'(0));
  endtask

  task automatic run_txn(input int gap);
    int s0;
    s0 = starts;
    push_expected();
    load_bytes(gap);
    drain();
    check("start_pulses", 144'(starts - s0), 144'(1));
    align();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 144'(s_ready), 144'(1));
    check({tag, "_mm_start"}, 144'(mm_start), 144'(0));
    check({tag, "_m_valid"}, 144'(m_valid), 144'(0));
    check({tag, "_m_data"}, 144'(m_data), 144'(0));
    check({tag, "_m_last"}, 144'(m_last), 144'(0));
    check({tag, "_err"}, 144'(err), 144'(0));
    check({tag, "_mm_A"}, 144'(mm_A), 144'(0));
    check({tag, "_mm_B"}, 144'(mm_B), 144'(0));
  endtask

  task automatic randomize_mats();
    for (int i = 0; i < 9; i++) begin
      a_m[i] = int'($urandom_range(0, 255));
      b_m[i] = int'($urandom_range(0, 255));
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, h0, t;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    align();

    for (int i = 0; i < 9; i++) begin a_m[i] = (i % 4 == 0) ? 1 : 0; b_m[i] = i + 1; end
    ready_mode = 0;
    run_txn(0);

    for (int i = 0; i < 9; i++) begin a_m[i] = 255; b_m[i] = 255; end
    run_txn(0);

    for (int i = 0; i < 9; i++) begin a_m[i] = (i % 4 == 0) ? 1 : 0; b_m[i] = i + 1; end
    ready_mode = 1;
    run_txn(0);

    ready_mode = 0;
    randomize_mats();
    run_txn(2);

    for (int r = 0; r < 4; r++) begin
      ready_mode = 2;
      mult_lat = int'($urandom_range(1, 8));
      randomize_mats();
      run_txn(int'($urandom_range(0, 3)));
    end

    ready_mode = 0;
    done_en = 0;
    randomize_mats();
    e0 = errs;
    valid_seen = 0;
    load_bytes(0);
    t = 0;
    while (errs == e0 && t < 600) begin t++; @(negedge clk); #1; end
    if (t >= 600) bound_fail("timeout_err");
    check("err_delay", 144'(err_cyc - start_cyc), 144'(TO + 2));
    repeat (5) @(negedge clk);
    #1;
    check("err_pulses", 144'(errs - e0), 144'(1));
    check("s_ready_after_timeout", 144'(s_ready), 144'(1));
    check("no_valid_on_timeout", 144'(valid_seen), 144'(0));
    done_en = 1;
    align();

    randomize_mats();
    push_expected();
    h0 = hs_count;
    load_bytes(0);
    t = 0;
    while (hs_count < h0 + 4 && t < 600) begin t++; @(negedge clk); #1; end
    if (t >= 600) bound_fail("stream_words");
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset_outputs("midreset");
    check("midreset_words", 144'(hs_count - h0), 144'(4));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    align();
    randomize_mats();
    s0 = starts;
    run_txn(1);
    check("post_reset_starts", 144'(starts - s0), 144'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
